mem_access_align: RTL

//  MEM-stage load/store unit. It narrows store data into byte lanes with byte enables, the

---
 rtl/mem_access_align.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_align.sv
// MEM-stage load/store unit: byte-lane store formatting, load extraction/extension,
// and a req/ack data-memory handshake with optional wait-cycle timeout.
module mem_access_align #(
    parameter int unsigned WAIT_LIMIT = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misaligned,
    output logic        rsp_timeout,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               write_q, write_d;
    logic [1:0]         size_q, size_d;
    logic               unsigned_q, unsigned_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_mis_q, rsp_mis_d;
    logic               rsp_to_q, rsp_to_d;

    logic               in_access;
    logic               req_misaligned;
    logic               timeout_hit;
    logic [3:0]         be_fmt;
    logic [31:0]        wdata_fmt;
    logic [31:0]        rdata_shift;
    logic [31:0]        load_ext;

    assign in_access = (state_q == ACCESS);

    assign req_misaligned = (req_size == 2'b11) ||
                            (req_size == 2'b01 && req_addr[0]) ||
                            (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    // The final counted ACCESS cycle is index WAIT_LIMIT-1; an ack in that cycle still wins.
    assign timeout_hit = (WAIT_LIMIT != 0) && (cnt_q == CNT_W'(WAIT_LIMIT - 1));

    always_comb begin
        be_fmt    = 4'b1111;
        wdata_fmt = wdata_q;
        case (size_q)
            2'b00: begin
                be_fmt    = 4'b0001 << addr_q[1:0];
                wdata_fmt = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_fmt    = 4'b0011 << addr_q[1:0];
                wdata_fmt = {2{wdata_q[15:0]}};
            end
            default: begin
                be_fmt    = 4'b1111;
                wdata_fmt = wdata_q;
            end
        endcase
    end

    assign rdata_shift = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = rdata_shift;
        case (size_q)
            2'b00:   load_ext = unsigned_q ? {24'h0, rdata_shift[7:0]}
                                           : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            2'b01:   load_ext = unsigned_q ? {16'h0, rdata_shift[15:0]}
                                           : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // Response flags are loaded only on the transition into RESP and read as zero otherwise.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = 32'h0;
        rsp_mis_d   = 1'b0;
        rsp_to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    cnt_d      = '0;
                    if (req_misaligned) begin
                        state_d   = RESP;
                        rsp_mis_d = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d     = RESP;
                    rsp_rdata_d = write_q ? 32'h0 : load_ext;
                end else if (timeout_hit) begin
                    state_d  = RESP;
                    rsp_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            cnt_q       <= '0;
            rsp_rdata_q <= 32'h0;
            rsp_mis_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_mis_q   <= rsp_mis_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign stall          = (state_q != IDLE);
    assign mem_req        = in_access;
    assign mem_we         = in_access & write_q;
    assign mem_addr       = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_be         = in_access ? be_fmt : 4'b0000;
    assign mem_wdata      = (in_access & write_q) ? wdata_fmt : 32'h0;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_misaligned = rsp_mis_q;
    assign rsp_timeout    = rsp_to_q;

endmodule
